// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game controller: state codes and the
// per-state strobe vector {R1,R2,E1,E2,E3,E4,SEL}.
package genius_pkg;

   localparam int ST_W  = 3;
   localparam int OUT_W = 7;

   typedef enum logic [ST_W-1:0] {
      S_INIT       = 3'd0,
      S_SETUP      = 3'd1,
      S_PLAY_FPGA  = 3'd2,
      S_PLAY_USER  = 3'd3,
      S_CHECK_USER = 3'd4,
      S_NEXT_ROUND = 3'd5,
      S_RESULT     = 3'd6
   } state_t;

   //                                            R1 R2 E1 E2 E3 E4 SEL
   localparam logic [OUT_W-1:0] OUT_INIT       = 7'b1_1_0_0_0_0_0;
   localparam logic [OUT_W-1:0] OUT_SETUP      = 7'b0_0_1_0_0_0_0;
   localparam logic [OUT_W-1:0] OUT_PLAY_FPGA  = 7'b0_0_0_0_1_0_0;
   localparam logic [OUT_W-1:0] OUT_PLAY_USER  = 7'b0_0_0_1_0_0_0;
   localparam logic [OUT_W-1:0] OUT_CHECK_USER = 7'b0_0_0_0_0_0_0;
   localparam logic [OUT_W-1:0] OUT_NEXT_ROUND = 7'b0_1_0_0_0_1_0;
   localparam logic [OUT_W-1:0] OUT_RESULT     = 7'b0_0_0_0_0_0_1;

   function automatic logic [OUT_W-1:0] state_outputs(input state_t s);
      case (s)
         S_INIT:       return OUT_INIT;
         S_SETUP:      return OUT_SETUP;
         S_PLAY_FPGA:  return OUT_PLAY_FPGA;
         S_PLAY_USER:  return OUT_PLAY_USER;
         S_CHECK_USER: return OUT_CHECK_USER;
         S_NEXT_ROUND: return OUT_NEXT_ROUND;
         S_RESULT:     return OUT_RESULT;
         default:      return OUT_INIT;
      endcase
   endfunction

endpackage

// File: rtl/genius_ctrl_btn_edge_sync.sv
// Synchronizes an active-low asynchronous pushbutton and emits a single
// one-cycle registered pulse on each press (falling edge).
module btn_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_n_i,
   output logic pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   pulse_q;

   // Reset to the released level so leaving reset never looks like a press.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '1;
         prev_q  <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
         prev_q  <= sync_q[SYNC_STAGES-1];
         pulse_q <= prev_q & ~sync_q[SYNC_STAGES-1];
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/genius_ctrl.sv
// Genius game control FSM with registered strobes decoded from next state.
// Optional GENIUS_AUTO_RESTART_EN: RESULT returns to INIT after RESULT_HOLD cycles.
module genius_ctrl #(
   parameter int SYNC_STAGES = 2,
`ifdef GENIUS_AUTO_RESTART_EN
   parameter int unsigned RESULT_HOLD = 500_000_000,
`endif
   parameter int ST_W = 3
) (
   input  logic            CLOCK_50,
   input  logic            reset,
   input  logic            enter_n,
   input  logic            end_FPGA,
   input  logic            end_User,
   input  logic            end_time,
   input  logic            win,
   input  logic            match,
   output logic            R1,
   output logic            R2,
   output logic            E1,
   output logic            E2,
   output logic            E3,
   output logic            E4,
   output logic            SEL,
   output logic [ST_W-1:0] state_o
);

   import genius_pkg::*;

   state_t           state_q, state_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             enter_pulse;
   logic             hold_done;

   btn_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_enter_sync (
      .clk_i  (CLOCK_50),
      .rst_i  (reset),
      .btn_n_i(enter_n),
      .pulse_o(enter_pulse)
   );

`ifdef GENIUS_AUTO_RESTART_EN
   logic [31:0] hold_q, hold_d;

   // Counts cycles spent in RESULT; zero whenever the FSM is elsewhere.
   always_comb begin
      hold_d = 32'd0;
      if (state_q == S_RESULT) hold_d = hold_q + 32'd1;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) hold_q <= 32'd0;
      else       hold_q <= hold_d;
   end

   assign hold_done = (hold_q == 32'(RESULT_HOLD - 1));
`else
   assign hold_done = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:       state_d = S_SETUP;
         S_SETUP:      if (enter_pulse) state_d = S_PLAY_FPGA;
         S_PLAY_FPGA:  if (end_FPGA) state_d = S_PLAY_USER;
         S_PLAY_USER: begin
            // Timeout wins over a simultaneous last entry.
            if (end_time)      state_d = S_RESULT;
            else if (end_User) state_d = S_CHECK_USER;
         end
         S_CHECK_USER: begin
            if (!match || win) state_d = S_RESULT;
            else               state_d = S_NEXT_ROUND;
         end
         S_NEXT_ROUND: state_d = S_PLAY_FPGA;
         S_RESULT:     if (enter_pulse || hold_done) state_d = S_INIT;
         default:      state_d = S_INIT;
      endcase
      out_d = state_outputs(state_d);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= S_INIT;
         out_q   <= OUT_INIT;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   assign {R1, R2, E1, E2, E3, E4, SEL} = out_q;
   assign state_o = ST_W'(state_q);

endmodule
